// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry, control codes and state encoding for the
// character-buffer write sequencer (vga_text_console) and its cursor
// sub-block (vga_cursor).
package vga_pkg;

  // Screen geometry: 80x30 tiles, linear address row*COLS+col.
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int TILES  = COLS * ROWS;
  localparam int ADDR_W = $clog2(TILES);

  // Control codes recognised in the byte stream.
  localparam logic [7:0] CC_BS = 8'h08;  // backspace
  localparam logic [7:0] CC_LF = 8'h0A;  // line feed: new row, cleared
  localparam logic [7:0] CC_FF = 8'h0C;  // form feed: full clear, home
  localparam logic [7:0] CC_CR = 8'h0D;  // carriage return: column 0
  localparam logic [7:0] BLANK = 8'h20;  // fill code for clears and backspace

  // Sequencer states.
  //   ST_IDLE    : no sequence running, stream accepted
  //   ST_PEND    : one cycle; printable write on the port before a line clear
  //   ST_CLRLINE : COLS writes of BLANK starting at the row base
  //   ST_CLEAR   : TILES writes of BLANK starting at address 0
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_CLRLINE = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_cursor.sv
// vga_cursor: hardware cursor for the text console.
// Holds column, row and the linear base address of the current row, so the
// tile address is base + col and no multiplier is needed.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   home            : cursor to (0,0), base 0 (highest priority)
//   line            : column 0, advance row (wrapping), base += COLS
//   cr              : column 0
//   bs              : column - 1 (ignored at column 0)
//   inc             : column + 1
//   col, row        : current cursor position
//   addr            : linear tile address of the cursor
//   row_base        : linear address of column 0 on the current row
//   next_base       : row base after a line advance (wraps to 0)
//   col_last        : cursor sits in the last column (column wrap pending)
//   col_zero        : cursor sits in column 0
module vga_cursor
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              home,
  input  logic              line,
  input  logic              cr,
  input  logic              bs,
  input  logic              inc,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] next_base,
  output logic              col_last,
  output logic              col_zero
);

  localparam logic [6:0]        COL_MAX  = 7'(COLS - 1);
  localparam logic [4:0]        ROW_MAX  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] BASE_MAX = ADDR_W'(TILES - COLS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  logic row_last;

  assign col_last  = (col == COL_MAX);
  assign col_zero  = (col == 7'd0);
  assign row_last  = (row == ROW_MAX);
  assign next_base = (row_base == BASE_MAX) ? '0 : row_base + COLS_A;
  assign addr      = row_base + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (line) begin
      col      <= '0;
      row      <= row_last ? '0 : row + 5'd1;
      row_base <= next_base;
    end else if (cr) begin
      col <= '0;
    end else if (bs) begin
      if (!col_zero) col <= col - 7'd1;
    end else if (inc) begin
      col <= col + 7'd1;
    end
  end

endmodule

// File: rtl/vga_text_console.sv
// vga_text_console: terminal-style write sequencer in front of the
// character-buffer write port. Software pushes bytes; the console keeps a
// cursor, turns printable codes and control codes into single-cycle buffer
// write strobes, and runs the multi-cycle line and screen clears itself.
//
// Handshake: a byte on char_i is taken at a rising edge where char_valid_i
// and char_ready_o are both high. char_ready_o is combinational
// ((state==IDLE) & ~clear_req_i); the source must hold char_i/char_valid_i
// stable until that edge. Resulting writes and cursor moves show on the
// registered outputs from the following cycle.
//
// Ports:
//   clk_i, rstn_i   : clock, asynchronous active-low reset
//   char_i          : character/control code
//   char_valid_i    : char_i valid
//   char_ready_o    : console accepts char_i this cycle
//   clear_req_i     : single-cycle request: clear screen, home cursor
//   buf_wdata_o     : {zeros, code} while strobing, else 0
//   buf_wstrb_o     : byte-0 strobe while strobing, else 0
//   buf_waddr_o     : tile address of the write
//   buf_wready_o    : one-cycle write strobe
//   cursor_col_o    : cursor column
//   cursor_row_o    : cursor row
//   busy_o          : PEND, line clear or screen clear in progress
module vga_text_console
  import vga_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [7:0]          char_i,
  input  logic                char_valid_i,
  output logic                char_ready_o,
  input  logic                clear_req_i,
  output logic [DATA_W-1:0]   buf_wdata_o,
  output logic [DATA_W/8-1:0] buf_wstrb_o,
  output logic [ADDR_W-1:0]   buf_waddr_o,
  output logic                buf_wready_o,
  output logic [6:0]          cursor_col_o,
  output logic [4:0]          cursor_row_o,
  output logic                busy_o
);

  localparam logic [ADDR_W-1:0]   CNT_COLS  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0]   CNT_TILES = ADDR_W'(TILES);
  localparam logic [ADDR_W-1:0]   ONE_A     = ADDR_W'(1);
  localparam logic [DATA_W/8-1:0] STRB_ON   = {{(DATA_W/8-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]   BLANK_W   = {{(DATA_W-8){1'b0}}, BLANK};

  state_t            state;
  logic [ADDR_W-1:0] cnt;       // writes issued in the running clear
  logic              accept;
  logic              printable;

  logic              cmd_home, cmd_line, cmd_cr, cmd_bs, cmd_inc;
  logic [ADDR_W-1:0] cur_addr, row_base, next_base;
  logic              col_last, col_zero;

  assign char_ready_o = (state == ST_IDLE) & ~clear_req_i;
  assign accept       = char_valid_i & char_ready_o;
  assign printable    = is_printable(char_i);

  // Cursor commands move in the same edge as the accepting handshake, so the
  // registered cursor outputs and the write strobe appear together.
  always_comb begin
    cmd_home = (state == ST_CLEAR) && (cnt == '0);
    cmd_inc  = accept && printable && !col_last;
    cmd_line = accept && ((printable && col_last) || (char_i == CC_LF));
    cmd_cr   = accept && (char_i == CC_CR);
    cmd_bs   = accept && (char_i == CC_BS) && !col_zero;
  end

  vga_cursor u_cursor (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .home      (cmd_home),
    .line      (cmd_line),
    .cr        (cmd_cr),
    .bs        (cmd_bs),
    .inc       (cmd_inc),
    .col       (cursor_col_o),
    .row       (cursor_row_o),
    .addr      (cur_addr),
    .row_base  (row_base),
    .next_base (next_base),
    .col_last  (col_last),
    .col_zero  (col_zero)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt          <= '0;
      buf_wready_o <= 1'b0;
      buf_wstrb_o  <= '0;
      buf_wdata_o  <= '0;
      buf_waddr_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      // Strobe fields drop to zero unless a branch below issues a write.
      buf_wready_o <= 1'b0;
      buf_wstrb_o  <= '0;
      buf_wdata_o  <= '0;
      case (state)
        ST_IDLE: begin
          busy_o <= 1'b0;
          if (clear_req_i) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            busy_o <= 1'b1;
          end else if (accept) begin
            if (printable) begin
              buf_wready_o <= 1'b1;
              buf_wstrb_o  <= STRB_ON;
              buf_wdata_o  <= {{(DATA_W-8){1'b0}}, char_i};
              buf_waddr_o  <= cur_addr;
              if (col_last) begin
                state  <= ST_PEND;
                busy_o <= 1'b1;
              end
            end else if (char_i == CC_LF) begin
              // First blank of the new row goes out with the handshake.
              buf_wready_o <= 1'b1;
              buf_wstrb_o  <= STRB_ON;
              buf_wdata_o  <= BLANK_W;
              buf_waddr_o  <= next_base;
              cnt          <= ONE_A;
              state        <= ST_CLRLINE;
              busy_o       <= 1'b1;
            end else if (char_i == CC_BS) begin
              if (!col_zero) begin
                buf_wready_o <= 1'b1;
                buf_wstrb_o  <= STRB_ON;
                buf_wdata_o  <= BLANK_W;
                buf_waddr_o  <= cur_addr - ONE_A;
              end
            end else if (char_i == CC_FF) begin
              state  <= ST_CLEAR;
              cnt    <= '0;
              busy_o <= 1'b1;
            end
          end
        end

        ST_PEND: begin
          busy_o <= 1'b1;
          if (clear_req_i) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else begin
            // Cursor already sits on the new row, so row_base is its start.
            buf_wready_o <= 1'b1;
            buf_wstrb_o  <= STRB_ON;
            buf_wdata_o  <= BLANK_W;
            buf_waddr_o  <= row_base;
            cnt          <= ONE_A;
            state        <= ST_CLRLINE;
          end
        end

        ST_CLRLINE: begin
          busy_o <= 1'b1;
          if (clear_req_i) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (cnt == CNT_COLS) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            // Line writes are consecutive, so step from the last address.
            buf_wready_o <= 1'b1;
            buf_wstrb_o  <= STRB_ON;
            buf_wdata_o  <= BLANK_W;
            buf_waddr_o  <= buf_waddr_o + ONE_A;
            cnt          <= cnt + ONE_A;
          end
        end

        ST_CLEAR: begin
          busy_o <= 1'b1;
          if (cnt == CNT_TILES) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            buf_wready_o <= 1'b1;
            buf_wstrb_o  <= STRB_ON;
            buf_wdata_o  <= BLANK_W;
            buf_waddr_o  <= cnt;
            cnt          <= cnt + ONE_A;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Terminal-style write sequencer in front of the vga_top character-buffer write port (80x30 tiles, linear address row*80+col, 0..2399).
- Accepts a byte stream over valid/ready and keeps a hardware cursor.
- Translates printable characters and control codes into single-cycle buffer write strobes.
- Runs multi-cycle line-clear and screen-clear sequences, so software only pushes characters.

Parameters:
- COLS, 80, tiles per row
- ROWS, 30, tile rows
- ADDR_W, 12, buffer address width ($clog2(COLS*ROWS))
- DATA_W, 32, buffer write-data width
- BLANK, 8'h20, fill code for clears and backspace
- CLEAR_ON_RESET, 1, run full-screen clear after reset release

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- char_i  in  8  character/control code
- char_valid_i  in  1  char_i valid
- char_ready_o  out  1  console accepts char_i this cycle
- clear_req_i  in  1  single-cycle request: clear screen, home cursor
- buf_wdata_o  out  DATA_W  {zeros, code}, to axil_wdata_i
- buf_wstrb_o  out  DATA_W/8  4'b0001 while strobing, else 0
- buf_waddr_o  out  ADDR_W  tile address
- buf_wready_o  out  1  one-cycle write strobe, to axil_wready_i
- cursor_col_o  out  7  cursor column 0..COLS-1
- cursor_row_o  out  5  cursor row 0..ROWS-1
- busy_o  out  1  clear sequence in progress

Behaviour:
- Reset (rstn_i low, asynchronous) drives all outputs to 0. State is IDLE, or CLEAR if CLEAR_ON_RESET=1.
- After reset release with CLEAR_ON_RESET=1, the full clear starts on the first clock edge.
- States:
  - IDLE: no sequence running.
  - PEND: one cycle; a printable write is on the port before a line clear.
  - CLRLINE: COLS writes of BLANK at the row base.
  - CLEAR: COLS*ROWS writes of BLANK from address 0.
- char_ready_o = (state==IDLE) & ~clear_req_i, combinational. Handshake occurs when valid & ready at edge N.
- All buf_* and cursor outputs are registered. Writes and cursor updates appear from cycle N+1.
- Printable codes 0x20..0x7E:
  - Write code at cursor, strobe on N+1.
  - If col<COLS-1: col+1, stay IDLE. Back-to-back sustains 1 char/cycle.
  - If col==COLS-1: col=0, row advances; PEND then CLRLINE on the new row, writes N+2..N+81; ready high again at N+82.
- 0x0D CR: col=0, no write.
- 0x0A LF: col=0, row advances; CLRLINE on the new row, writes N+1..N+80; ready at N+81.
- 0x08 BS:
  - If col>0: col-1 and write BLANK at the new position on N+1.
  - If col==0: no-op, consumed.
- 0x0C FF: same as clear_req_i.
- All other codes: consumed, no effect.
- Row advance wraps ROWS-1 to 0. There is no scrolling; the line clear makes the new row blank.
- Address is maintained incrementally with a row base: base += COLS, wrapping at COLS*ROWS. No multiplier.
- CLEAR:
  - Writes addresses 0..COLS*ROWS-1 on consecutive cycles.
  - Cursor is set to (0,0) on the first clear cycle.
  - IDLE follows the cycle after the last write.
- busy_o is high in PEND, CLRLINE and CLEAR.
- Priority rules:
  - clear_req_i in IDLE wins over a simultaneous char_valid_i. The char is not accepted and stays pending at the source.
  - clear_req_i in PEND/CLRLINE aborts the line clear; CLEAR starts at address 0 next cycle.
  - clear_req_i in CLEAR is ignored; the sequence does not restart.
- buf_wready_o is never asserted two cycles for the same address except via clear restart.
- buf_wstrb_o and buf_wdata_o are 0 when no strobe is active.

Decomposition:
- Package vga_pkg holds:
  - COLS, ROWS, TILES=COLS*ROWS, ADDR_W
  - control-code constants CC_CR, CC_LF, CC_BS, CC_FF, BLANK
  - state enum
- One natural sub-module, vga_cursor:
  - col/row/row-base registers with advance, backspace, home and line-advance commands
  - outputs the linear address and wrap flags

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> 2400 consecutive strobes, data 0x20, addr 0..2399. char_ready_o low throughout, high the cycle after. Cursor (0,0).
- 'A' (65) then 'C' (67) on consecutive cycles from home -> strobes addr 0 data 65, then addr 1 data 67 on consecutive cycles. Cursor (2,0).
- Cursor (79,29), send 'Z' -> strobe addr 2399 data 0x5A, then 80 strobes 0x20 at addr 0..79. Cursor (0,0). Ready returns at N+82.
- Cursor (5,3), sequence:
  - BS -> strobe addr 244 data 0x20, cursor (4,3).
  - CR -> no strobe, cursor (0,3).
  - BS -> no strobe.
  - LF -> 80 strobes at 320..399, cursor (0,4).
  - 0x07 -> consumed, no strobe.
- During CLRLINE, at the 40th write: pulse clear_req_i with char_valid_i high -> next strobe addr 0, 2400 writes total, char not accepted until IDLE. Cursor (0,0).
- Drop rstn_i asynchronously mid-clear at addr 1000 -> buf_wready_o and all outputs 0 immediately. After release, clear restarts at addr 0.
